// File: rtl/s1s2_phase_ctrl_pkg.sv
// Shared definitions for the S1S2 phase sequencer: state encoding, RAM port
// ownership and the default field/code size macros.
`ifndef S1S2_PHASE_CTRL_PKG_SV
`define S1S2_PHASE_CTRL_PKG_SV

`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif
`ifndef M
`define M 8
`endif
`ifndef N
`define N 16
`endif

package s1s2_phase_ctrl_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_GEN   = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_CONS  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_GEN  = 2'd1,
    OWN_CONS = 2'd2
  } owner_e;

  // The generator keeps the port through DRAIN so its registered writes land.
  function automatic owner_e ownerOf(input logic [2:0] st);
    case (st)
      S_GEN, S_DRAIN: return OWN_GEN;
      S_CONS:         return OWN_CONS;
      default:        return OWN_NONE;
    endcase
  endfunction

endpackage

`endif

// File: rtl/s1s2_port_mux.sv
// Registered arbiter for the single-port S1S2 RAM: forwards the owner's
// request one cycle later and parks the port when nobody owns it.
module s1s2_port_mux
  import s1s2_phase_ctrl_pkg::*;
#(
  parameter int DW = 2 * `M,
  parameter int AW = `CLOG2(2 * `N)
) (
  input  logic          clk,
  input  logic          rst_b,
  input  owner_e        i_owner,
  input  logic [DW-1:0] gen_dout,
  input  logic [AW-1:0] gen_addr,
  input  logic          gen_rw,
  input  logic [DW-1:0] cons_dout,
  input  logic [AW-1:0] cons_addr,
  input  logic          cons_rw,
  output logic [DW-1:0] mem_din,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rw
);

  logic [DW-1:0] r_din;
  logic [AW-1:0] r_addr;
  logic          r_rw;

  // When parked, din is left alone so the data bus does not toggle needlessly.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_din  <= '0;
      r_addr <= '0;
      r_rw   <= 1'b0;
    end else begin
      case (i_owner)
        OWN_GEN: begin
          r_din  <= gen_dout;
          r_addr <= gen_addr;
          r_rw   <= gen_rw;
        end
        OWN_CONS: begin
          r_din  <= cons_dout;
          r_addr <= cons_addr;
          r_rw   <= cons_rw;
        end
        default: begin
          r_addr <= '0;
          r_rw   <= 1'b0;
        end
      endcase
    end
  end

  assign mem_din  = r_din;
  assign mem_addr = r_addr;
  assign mem_rw   = r_rw;

endmodule

// File: rtl/s1s2_phase_ctrl.sv
// S1S2 stage sequencer: generator phase, write-drain wait, consumer phase.
// Optional macro CYCLE_CNT_EN adds the cycle_cnt runtime output.
module s1s2_phase_ctrl
  import s1s2_phase_ctrl_pkg::*;
#(
  parameter int m     = `M,
  parameter int n     = `N,
  parameter int DRAIN = 2,
  parameter int AW    = `CLOG2(2 * n)
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  output logic             finish,
  output logic             busy,
  output logic             gen_start,
  input  logic             gen_finish,
  input  logic [2*m-1:0]   gen_dout,
  input  logic [AW-1:0]    gen_addr,
  input  logic             gen_rw,
  output logic             cons_start,
  input  logic             cons_finish,
  input  logic [2*m-1:0]   cons_dout,
  input  logic [AW-1:0]    cons_addr,
  input  logic             cons_rw,
  output logic [2*m-1:0]   mem_din,
  output logic [AW-1:0]    mem_addr,
  output logic             mem_rw
`ifdef CYCLE_CNT_EN
  ,
  output logic [31:0]      cycle_cnt
`endif
);

  localparam int CW = (DRAIN > 1) ? $clog2(DRAIN) : 1;

  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_gen_start;
  logic          r_cons_start;
  owner_e        w_owner;

  // Each state only listens to its own trigger, so stray or simultaneous
  // finish pulses from the inactive requester fall through harmlessly.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_gen_start  <= 1'b0;
      r_cons_start <= 1'b0;
    end else begin
      r_gen_start  <= 1'b0;
      r_cons_start <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_state     <= S_GEN;
          r_gen_start <= 1'b1;
        end
        S_GEN: if (gen_finish) begin
          if (DRAIN == 0) begin
            r_state      <= S_CONS;
            r_cons_start <= 1'b1;
          end else begin
            r_state <= S_DRAIN;
            r_cnt   <= CW'(DRAIN - 1);
          end
        end
        S_DRAIN: begin
          if (r_cnt == '0) begin
            r_state      <= S_CONS;
            r_cons_start <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_CONS: if (cons_finish) r_state <= S_DONE;
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gen_start  = r_gen_start;
  assign cons_start = r_cons_start;
  assign finish     = (r_state == S_DONE);
  assign busy       = (r_state == S_GEN) || (r_state == S_DRAIN) || (r_state == S_CONS);
  assign w_owner    = ownerOf(r_state);

  s1s2_port_mux #(
    .DW (2 * m),
    .AW (AW)
  ) u_port_mux (
    .clk       (clk),
    .rst_b     (rst_b),
    .i_owner   (w_owner),
    .gen_dout  (gen_dout),
    .gen_addr  (gen_addr),
    .gen_rw    (gen_rw),
    .cons_dout (cons_dout),
    .cons_addr (cons_addr),
    .cons_rw   (cons_rw),
    .mem_din   (mem_din),
    .mem_addr  (mem_addr),
    .mem_rw    (mem_rw)
  );

`ifdef CYCLE_CNT_EN
  logic [31:0] r_cycle_cnt;

  // Counting through the DONE cycle makes the value equal start-to-finish latency.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_cycle_cnt <= '0;
    end else if (r_state == S_IDLE) begin
      if (start) r_cycle_cnt <= '0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + 32'd1;
    end
  end

  assign cycle_cnt = r_cycle_cnt;
`endif

endmodule

// File: tb/tb_s1s2_phase_ctrl.sv
// Directed self-checking bench for s1s2_phase_ctrl (DRAIN=2 main instance,
// plus a DRAIN=0 instance sharing the same stimulus).
module tb_s1s2_phase_ctrl;

  localparam int MW = `M;
  localparam int NN = `N;
  localparam int DW = 2 * MW;
  localparam int AW = `CLOG2(2 * NN);

  logic          clk;
  logic          rst_b;
  logic          start;
  logic          gen_finish;
  logic [DW-1:0] gen_dout;
  logic [AW-1:0] gen_addr;
  logic          gen_rw;
  logic          cons_finish;
  logic [DW-1:0] cons_dout;
  logic [AW-1:0] cons_addr;
  logic          cons_rw;

  logic          finish, busy, gen_start, cons_start, mem_rw;
  logic [DW-1:0] mem_din;
  logic [AW-1:0] mem_addr;

  logic          z_finish, z_busy, z_gen_start, z_cons_start, z_mem_rw;
  logic [DW-1:0] z_mem_din;
  logic [AW-1:0] z_mem_addr;

`ifdef CYCLE_CNT_EN
  logic [31:0]   cycle_cnt;
  logic [31:0]   z_cycle_cnt;
`endif

  int cyc;
  int nCompared;
  int nMismatched;

  s1s2_phase_ctrl #(.m(MW), .n(NN), .DRAIN(2), .AW(AW)) dut (
    .clk(clk), .rst_b(rst_b), .start(start), .finish(finish), .busy(busy),
    .gen_start(gen_start), .gen_finish(gen_finish), .gen_dout(gen_dout),
    .gen_addr(gen_addr), .gen_rw(gen_rw), .cons_start(cons_start),
    .cons_finish(cons_finish), .cons_dout(cons_dout), .cons_addr(cons_addr),
    .cons_rw(cons_rw), .mem_din(mem_din), .mem_addr(mem_addr), .mem_rw(mem_rw)
`ifdef CYCLE_CNT_EN
    , .cycle_cnt(cycle_cnt)
`endif
  );

  s1s2_phase_ctrl #(.m(MW), .n(NN), .DRAIN(0), .AW(AW)) dut0 (
    .clk(clk), .rst_b(rst_b), .start(start), .finish(z_finish), .busy(z_busy),
    .gen_start(z_gen_start), .gen_finish(gen_finish), .gen_dout(gen_dout),
    .gen_addr(gen_addr), .gen_rw(gen_rw), .cons_start(z_cons_start),
    .cons_finish(cons_finish), .cons_dout(cons_dout), .cons_addr(cons_addr),
    .cons_rw(cons_rw), .mem_din(z_mem_din), .mem_addr(z_mem_addr), .mem_rw(z_mem_rw)
`ifdef CYCLE_CNT_EN
    , .cycle_cnt(z_cycle_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance whole cycles; inputs change 1 time unit after the rising edge.
  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  initial begin
    cyc = 0; nCompared = 0; nMismatched = 0;
    rst_b = 1'b0; start = 1'b0; gen_finish = 1'b0; cons_finish = 1'b0;
    gen_dout = '0; gen_addr = '0; gen_rw = 1'b0;
    cons_dout = '0; cons_addr = '0; cons_rw = 1'b0;

    applyStimulus(2);
    checkOutput("rst_finish", 32'(finish), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_gen_start", 32'(gen_start), 32'd0);
    checkOutput("rst_cons_start", 32'(cons_start), 32'd0);
    checkOutput("rst_mem_rw", 32'(mem_rw), 32'd0);
    checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("rst_mem_din", 32'(mem_din), 32'd0);
`ifdef CYCLE_CNT_EN
    checkOutput("rst_cycle_cnt", cycle_cnt, 32'd0);
`endif
    rst_b = 1'b1;
    applyStimulus(1);

    // Nominal run: cycle 0 is the start cycle.
    cyc = 0;
    start = 1'b1;
    applyStimulus(1);
    start = 1'b0;
    checkOutput("gen_start_c1", 32'(gen_start), 32'd1);
    checkOutput("busy_c1", 32'(busy), 32'd1);
    cons_rw = 1'b1; cons_addr = AW'(7);
    applyStimulus(1);
    checkOutput("gen_start_c2", 32'(gen_start), 32'd0);
    applyStimulus(1);
    checkOutput("cons_rw_in_gen", 32'(mem_rw), 32'd0);
    checkOutput("gen_addr0_in_gen", 32'(mem_addr), 32'd0);
    gen_rw = 1'b1; gen_addr = AW'(3); gen_dout = DW'(16'h1234);
    applyStimulus(1);
    checkOutput("gen_rw_c4", 32'(mem_rw), 32'd1);
    checkOutput("gen_addr_c4", 32'(mem_addr), 32'd3);
    checkOutput("gen_din_c4", 32'(mem_din), 32'(DW'(16'h1234)));
    gen_rw = 1'b0; cons_rw = 1'b0;
    start = 1'b1; cons_finish = 1'b1;
    applyStimulus(1);
    start = 1'b0; cons_finish = 1'b0;
    checkOutput("stray_busy", 32'(busy), 32'd1);
    checkOutput("stray_gen_start", 32'(gen_start), 32'd0);
    checkOutput("stray_finish", 32'(finish), 32'd0);
    applyStimulus(1);
    checkOutput("stray_finish2", 32'(finish), 32'd0);
    checkOutput("stray_cons_start", 32'(cons_start), 32'd0);
    applyStimulus(40 - cyc);

    gen_finish = 1'b1; cons_finish = 1'b1;
    applyStimulus(1);
    gen_finish = 1'b0; cons_finish = 1'b0;
    checkOutput("both_fin_finish_c41", 32'(finish), 32'd0);
    checkOutput("both_fin_busy_c41", 32'(busy), 32'd1);
    checkOutput("cons_start_c41", 32'(cons_start), 32'd0);
    checkOutput("d0_cons_start_c41", 32'(z_cons_start), 32'd1);
    gen_rw = 1'b1; gen_addr = AW'(5); gen_dout = DW'(16'hBEEF);
    applyStimulus(1);
    gen_rw = 1'b0;
    checkOutput("drain_rw_c42", 32'(mem_rw), 32'd1);
    checkOutput("drain_addr_c42", 32'(mem_addr), 32'd5);
    checkOutput("drain_din_c42", 32'(mem_din), 32'(DW'(16'hBEEF)));
    checkOutput("cons_start_c42", 32'(cons_start), 32'd0);
    applyStimulus(1);
    checkOutput("cons_start_c43", 32'(cons_start), 32'd1);
    checkOutput("busy_c43", 32'(busy), 32'd1);

    gen_finish = 1'b1; gen_rw = 1'b1; cons_addr = AW'(9);
    applyStimulus(1);
    gen_finish = 1'b0; gen_rw = 1'b0;
    checkOutput("gen_rw_in_cons", 32'(mem_rw), 32'd0);
    checkOutput("cons_addr_c44", 32'(mem_addr), 32'd9);
    checkOutput("cons_start_c44", 32'(cons_start), 32'd0);
    checkOutput("stray_gen_fin_finish", 32'(finish), 32'd0);
    cons_rw = 1'b1; cons_dout = DW'(16'h0F0F);
    applyStimulus(1);
    cons_rw = 1'b0;
    checkOutput("cons_rw_c45", 32'(mem_rw), 32'd1);
    checkOutput("cons_din_c45", 32'(mem_din), 32'(DW'(16'h0F0F)));
    applyStimulus(60 - cyc);
    checkOutput("busy_c60", 32'(busy), 32'd1);
    cons_finish = 1'b1;
    applyStimulus(1);
    cons_finish = 1'b0;
    checkOutput("finish_c61", 32'(finish), 32'd1);
    checkOutput("busy_c61", 32'(busy), 32'd0);
    checkOutput("d0_finish_c61", 32'(z_finish), 32'd1);
    applyStimulus(1);
    checkOutput("finish_c62", 32'(finish), 32'd0);
    checkOutput("idle_rw_c62", 32'(mem_rw), 32'd0);
    checkOutput("idle_addr_c62", 32'(mem_addr), 32'd0);
    checkOutput("idle_din_hold_c62", 32'(mem_din), 32'(DW'(16'h0F0F)));
`ifdef CYCLE_CNT_EN
    checkOutput("cycle_cnt_c62", cycle_cnt, 32'd61);
    applyStimulus(3);
    checkOutput("cycle_cnt_hold", cycle_cnt, 32'd61);
`endif

    // Reset while the consumer owns the port and is writing.
    cyc = 0;
    start = 1'b1;
    applyStimulus(1);
    start = 1'b0;
    checkOutput("run2_gen_start", 32'(gen_start), 32'd1);
`ifdef CYCLE_CNT_EN
    checkOutput("cycle_cnt_cleared", cycle_cnt, 32'd0);
`endif
    gen_finish = 1'b1;
    applyStimulus(1);
    gen_finish = 1'b0;
    applyStimulus(2);
    checkOutput("run2_cons_start", 32'(cons_start), 32'd1);
    cons_rw = 1'b1; cons_addr = AW'(11);
    applyStimulus(1);
    checkOutput("run2_cons_rw", 32'(mem_rw), 32'd1);
    checkOutput("run2_cons_addr", 32'(mem_addr), 32'd11);
    rst_b = 1'b0;
    applyStimulus(1);
    checkOutput("midrst_mem_rw", 32'(mem_rw), 32'd0);
    checkOutput("midrst_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    rst_b = 1'b1; cons_rw = 1'b0;
    applyStimulus(1);

    // Short run after reset must behave normally.
    cyc = 0;
    start = 1'b1;
    applyStimulus(1);
    start = 1'b0;
    checkOutput("run3_gen_start", 32'(gen_start), 32'd1);
    gen_finish = 1'b1;
    applyStimulus(1);
    gen_finish = 1'b0;
    applyStimulus(1);
    checkOutput("run3_cons_start_early", 32'(cons_start), 32'd0);
    applyStimulus(1);
    checkOutput("run3_cons_start", 32'(cons_start), 32'd1);
    cons_finish = 1'b1;
    applyStimulus(1);
    cons_finish = 1'b0;
    checkOutput("run3_finish", 32'(finish), 32'd1);
    checkOutput("run3_busy", 32'(busy), 32'd0);
`ifdef CYCLE_CNT_EN
    applyStimulus(1);
    checkOutput("run3_cycle_cnt", cycle_cnt, 32'd5);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
